// File: rtl/bemf_pkg.sv
`default_nettype none
// ==========================================================================
// bemf_pkg : shared constants and helpers for the back-EMF integrator
// Rev 1.0
// ==========================================================================
package bemf_pkg;

  localparam int DB_POS_DEF = 20;
  localparam int DB_NEG_DEF = 22;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single-channel build still needs a one-bit channel field.
  function automatic int ch_w_f(input int n_ch);
    return (n_ch < 2) ? 1 : clog2_f(n_ch);
  endfunction

  // Clamp limits are produced at 64 bits and sliced down to the accumulator width.
  function automatic logic signed [63:0] acc_max_f(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min_f(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bemf_sat_add.sv
`default_nettype none
// ==========================================================================
// bemf_sat_add : combinational signed add that clamps instead of wrapping
// Rev 1.0
// ==========================================================================
module bemf_sat_add
  import bemf_pkg::*;
#(
  parameter int W = 36
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);

  localparam logic signed [63:0]  C_MAX64 = acc_max_f(W);
  localparam logic signed [63:0]  C_MIN64 = acc_min_f(W);
  localparam logic signed [W-1:0] C_MAX   = C_MAX64[W-1:0];
  localparam logic signed [W-1:0] C_MIN   = C_MIN64[W-1:0];

  logic [W:0] sum_wide;

  // One guard bit: a disagreement between the top two bits means overflow.
  always_comb begin
    sum_wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    if (sum_wide[W] != sum_wide[W-1]) begin
      sum_o = sum_wide[W] ? C_MIN : C_MAX;
    end else begin
      sum_o = sum_wide[W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/bemf_integrator.sv
`default_nettype none
// ==========================================================================
// bemf_integrator : 4-stage back-EMF integrator, per-channel saturating sums
// Optional velocity output enabled by defining BEMF_VEL_OUT_EN.   Rev 1.0
// ==========================================================================
module bemf_integrator
  import bemf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADC_W  = 10,
  parameter int ACC_W  = 36,
  parameter int DB_POS = DB_POS_DEF,
  parameter int DB_NEG = DB_NEG_DEF,
  localparam int CH_W  = ch_w_f(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADC_W-1:0]        adc_h_i,
  input  logic [ADC_W-1:0]        adc_l_i,
  input  logic [CH_W-1:0]         ch_sel_i,
  input  logic                    in_valid_i,
  input  logic [ACC_W-1:0]        calib_i,
  input  logic [NUM_CH-1:0]       clr_i,
  output logic [NUM_CH*ACC_W-1:0] acc_out_o,
  output logic                    out_valid_o,
  output logic [CH_W-1:0]         out_ch_o,
`ifdef BEMF_VEL_OUT_EN
  output logic [ACC_W-1:0]        vel_out_o,
`endif
  output logic                    drop_err_o
);

  localparam logic signed [ACC_W-1:0] C_DB_POS = ACC_W'(DB_POS);
  localparam logic signed [ACC_W-1:0] C_DB_NEG = ACC_W'(-DB_NEG);

  logic                    s0_vld_q;
  logic [ADC_W-1:0]        s0_h_q, s0_l_q;
  logic [CH_W-1:0]         s0_ch_q;
  logic signed [ACC_W-1:0] s0_cal_q;

  logic                    s1_vld_q;
  logic [CH_W-1:0]         s1_ch_q;
  logic signed [ACC_W-1:0] s1_diff_q, s1_diff_d, s1_cal_q;

  logic                    s2_vld_q;
  logic [CH_W-1:0]         s2_ch_q;
  logic signed [ACC_W-1:0] s2_inc_q, s2_inc_d, s2_cal;

  logic signed [ACC_W-1:0] acc_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_sel, acc_sum_d;
  logic                    out_valid_q, drop_err_q, ch_ok;
  logic [CH_W-1:0]         out_ch_q;

  assign ch_ok = ({1'b0, ch_sel_i} < (CH_W+1)'(NUM_CH));

  always_comb begin
    s1_diff_d = {{(ACC_W-ADC_W){1'b0}}, s0_h_q} - {{(ACC_W-ADC_W){1'b0}}, s0_l_q};
    s2_cal    = s1_diff_q - s1_cal_q;
    s2_inc_d  = ((s2_cal > C_DB_POS) || (s2_cal < C_DB_NEG)) ? s2_cal : '0;
    acc_sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s2_ch_q == CH_W'(i)) acc_sel = acc_q[i];
    end
  end

  bemf_sat_add #(.W(ACC_W)) u_sat_add (
    .a_i   (acc_sel),
    .b_i   (s2_inc_q),
    .sum_o (acc_sum_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld_q    <= 1'b0;
      s0_h_q      <= '0;
      s0_l_q      <= '0;
      s0_ch_q     <= '0;
      s0_cal_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_ch_q     <= '0;
      s1_diff_q   <= '0;
      s1_cal_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_ch_q     <= '0;
      s2_inc_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      drop_err_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      // Out-of-range channels never enter the pipeline.
      s0_vld_q  <= in_valid_i && ch_ok;
      if (in_valid_i) begin
        s0_h_q   <= adc_h_i;
        s0_l_q   <= adc_l_i;
        s0_ch_q  <= ch_sel_i;
        s0_cal_q <= calib_i;
      end
      if (in_valid_i && !ch_ok) drop_err_q <= 1'b1;

      s1_vld_q  <= s0_vld_q;
      s1_ch_q   <= s0_ch_q;
      s1_diff_q <= s1_diff_d;
      s1_cal_q  <= s0_cal_q;

      s2_vld_q  <= s1_vld_q;
      s2_ch_q   <= s1_ch_q;
      s2_inc_q  <= s2_inc_d;

      // Clear takes priority over a same-edge update of that channel.
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_i[i]) begin
          acc_q[i] <= '0;
        end else if (s2_vld_q && (s2_ch_q == CH_W'(i))) begin
          acc_q[i] <= acc_sum_d;
        end
      end
      out_valid_q <= s2_vld_q;
      if (s2_vld_q) out_ch_q <= s2_ch_q;
    end
  end

`ifdef BEMF_VEL_OUT_EN
  logic signed [ACC_W-1:0] vel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vel_q <= '0;
    end else if (s2_vld_q) begin
      vel_q <= s2_inc_q;
    end
  end

  assign vel_out_o = vel_q;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_acc_flat
    assign acc_out_o[gi*ACC_W +: ACC_W] = acc_q[gi];
  end

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign drop_err_o  = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bemf_integrator.sv
`default_nettype none
// ==========================================================================
// tb_bemf_integrator : scoreboard bench, 4-ch/36-bit and 3-ch/12-bit builds
// Rev 1.0
// ==========================================================================
module tb_bemf_integrator;

  localparam int AW = 36;
  localparam int BW = 12;

  typedef struct {
    int     ch;
    longint acc;
    longint vel;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic [9:0]      a_h = '0, a_l = '0, b_h = '0, b_l = '0;
  logic [1:0]      a_ch = '0, b_ch = '0;
  logic            a_v = 1'b0, b_v = 1'b0;
  logic [AW-1:0]   a_cal = '0;
  logic [BW-1:0]   b_cal = '0;
  logic [3:0]      a_clr = '0;
  logic [2:0]      b_clr = '0;
  logic [4*AW-1:0] a_acc;
  logic [3*BW-1:0] b_acc;
  logic            a_ov, b_ov, a_drop, b_drop;
  logic [1:0]      a_och, b_och;
`ifdef BEMF_VEL_OUT_EN
  logic [AW-1:0]   a_vel;
  logic [BW-1:0]   b_vel;
`endif

  exp_t   qa[$];
  exp_t   qb[$];
  longint ma[4];
  longint mb[3];
  int     total = 0;
  int     bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bemf_integrator #(.NUM_CH(4), .ADC_W(10), .ACC_W(AW)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .adc_h_i     (a_h),
    .adc_l_i     (a_l),
    .ch_sel_i    (a_ch),
    .in_valid_i  (a_v),
    .calib_i     (a_cal),
    .clr_i       (a_clr),
    .acc_out_o   (a_acc),
    .out_valid_o (a_ov),
    .out_ch_o    (a_och),
`ifdef BEMF_VEL_OUT_EN
    .vel_out_o   (a_vel),
`endif
    .drop_err_o  (a_drop)
  );

  bemf_integrator #(.NUM_CH(3), .ADC_W(10), .ACC_W(BW)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .adc_h_i     (b_h),
    .adc_l_i     (b_l),
    .ch_sel_i    (b_ch),
    .in_valid_i  (b_v),
    .calib_i     (b_cal),
    .clr_i       (b_clr),
    .acc_out_o   (b_acc),
    .out_valid_o (b_ov),
    .out_ch_o    (b_och),
`ifdef BEMF_VEL_OUT_EN
    .vel_out_o   (b_vel),
`endif
    .drop_err_o  (b_drop)
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint inc_f(input int h, input int l, input longint cal);
    longint c;
    c = longint'(h - l) - cal;
    return ((c > 20) || (c < -22)) ? c : 64'sd0;
  endfunction

  function automatic longint sat_f(input longint s, input int w);
    longint lim;
    lim = 64'sd1 <<< (w - 1);
    if (s > lim - 1) return lim - 1;
    if (s < -lim) return -lim;
    return s;
  endfunction

  function automatic longint a_slot(input int ch);
    return longint'($signed(a_acc[ch*AW +: AW]));
  endfunction

  function automatic longint b_slot(input int ch);
    return longint'($signed(b_acc[ch*BW +: BW]));
  endfunction

  // mode 0: normal, 1: lost to a same-edge clear, 2: no output expected
  task automatic send_a(input int ch, input int h, input int l, input longint cal, input int mode);
    exp_t e;
    longint inc;
    a_ch = 2'(ch); a_h = 10'(h); a_l = 10'(l); a_cal = AW'(cal); a_v = 1'b1;
    inc = inc_f(h, l, cal);
    if (mode != 2) begin
      ma[ch] = (mode == 1) ? 64'sd0 : sat_f(ma[ch] + inc, AW);
      e.ch = ch; e.acc = ma[ch]; e.vel = inc; e.cyc = cyc;
      qa.push_back(e);
    end
    @(posedge clk);
    #1;
    a_v = 1'b0;
    a_cal = AW'($urandom);
  endtask

  task automatic send_b(input int ch, input int h, input int l, input longint cal, input int mode);
    exp_t e;
    longint inc;
    b_ch = 2'(ch); b_h = 10'(h); b_l = 10'(l); b_cal = BW'(cal); b_v = 1'b1;
    inc = inc_f(h, l, cal);
    if (mode != 2) begin
      mb[ch] = sat_f(mb[ch] + inc, BW);
      e.ch = ch; e.acc = mb[ch]; e.vel = inc; e.cyc = cyc;
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
    b_v = 1'b0;
    b_cal = BW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_monitor;
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_ov) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_out_ch", longint'(a_och), longint'(e.ch));
          chk("a_acc", a_slot(e.ch), e.acc);
          chk("a_latency", longint'(cyc - e.cyc), 4);
`ifdef BEMF_VEL_OUT_EN
          chk("a_vel", longint'($signed(a_vel)), e.vel);
`endif
        end
      end
      if (b_ov) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_out_ch", longint'(b_och), longint'(e.ch));
          chk("b_acc", b_slot(e.ch), e.acc);
          chk("b_latency", longint'(cyc - e.cyc), 4);
`ifdef BEMF_VEL_OUT_EN
          chk("b_vel", longint'($signed(b_vel)), e.vel);
`endif
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ma[i] = 0;
    for (int i = 0; i < 3; i++) mb[i] = 0;
    fork
      run_monitor();
    join_none

    // Reset state
    idle(3);
    rst = 1'b0;
    chk("rst_acc_a_nonzero", longint'(a_acc != '0), 0);
    chk("rst_acc_b_nonzero", longint'(b_acc != '0), 0);
    chk("rst_out_valid", longint'(a_ov | b_ov), 0);
    chk("rst_out_ch", longint'(a_och), 0);
    chk("rst_drop_err", longint'(a_drop | b_drop), 0);

    // Single sample on channel 0
    send_a(0, 600, 100, 0, 0);
    idle(6);
    chk("t1_acc0", a_slot(0), 500);
    chk("t1_others_zero", longint'(a_acc[4*AW-1:AW] != '0), 0);
`ifdef BEMF_VEL_OUT_EN
    chk("t1_vel", longint'($signed(a_vel)), 500);
`endif

    // Deadband edges on channel 1
    send_a(1, 100, 100, 0, 0);
    send_a(1, 100, 100, -20, 0);
    send_a(1, 100, 100, -21, 0);
    send_a(1, 100, 100, 0, 0);
    send_a(1, 100, 100, 22, 0);
    send_a(1, 100, 100, 23, 0);
    idle(6);
    chk("t2_acc1", a_slot(1), -2);

    // Back-to-back same channel
    for (int i = 0; i < 8; i++) send_a(2, 300, 0, 0, 0);
    idle(6);
    chk("t3_acc2", a_slot(2), 2400);
    chk("t3_queue_drained", longint'(qa.size()), 0);

    // Clear lands on the same edge as the channel-0 update
    send_a(0, 600, 100, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    a_clr = 4'b0001;
    @(posedge clk);
    #1;
    a_clr = 4'b0000;
    idle(3);
    chk("t5_clr_acc0", a_slot(0), 0);
    chk("t5_clr_acc1_kept", a_slot(1), -2);

    // Reset with samples in flight
    send_a(3, 500, 0, 0, 2);
    send_a(3, 500, 0, 0, 2);
    send_a(3, 500, 0, 0, 2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ma[i] = 0;
    idle(8);
    chk("t5_rst_acc_a_nonzero", longint'(a_acc != '0), 0);

    // Narrow build: saturate high then low
    for (int i = 0; i < 4; i++) send_b(2, 1000, 0, 0, 0);
    idle(6);
    chk("t4_sat_max", b_slot(2), 2047);
    for (int i = 0; i < 6; i++) send_b(2, 0, 1000, 0, 0);
    idle(6);
    chk("t4_sat_min", b_slot(2), -2048);

    // Out-of-range channel on the 3-channel build
    send_b(3, 900, 0, 0, 2);
    idle(6);
    chk("t6_drop_err", longint'(b_drop), 1);
    chk("t6_acc2_unchanged", b_slot(2), -2048);
    chk("t6_acc01_unchanged", longint'(b_acc[2*BW-1:0] != '0), 0);
    chk("t6_a_no_drop", longint'(a_drop), 0);
    idle(4);
    chk("t6_drop_sticky", longint'(b_drop), 1);

    chk("end_qa_left", longint'(qa.size()), 0);
    chk("end_qb_left", longint'(qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
